// File: rtl/sat_counter_table.sv
// Pattern-history table of saturating counters with combinational lookups, one RMW update port
// and a sequential init sweep after reset or flush.
module sat_counter_table #(
  parameter int unsigned S_INDEX    = 10,
  parameter int unsigned CTR_WIDTH  = 2,
  parameter int unsigned INIT_VALUE = 1,
  parameter int unsigned NUM_RD     = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [NUM_RD*S_INDEX-1:0]     rd_index,
  output logic [NUM_RD*CTR_WIDTH-1:0]   rd_ctr,
  output logic [NUM_RD-1:0]             rd_taken,
  input  logic                          upd_valid,
  input  logic [S_INDEX-1:0]            upd_index,
  input  logic                          upd_taken,
  output logic                          ready
);

  localparam int unsigned            Depth   = 2 ** S_INDEX;
  localparam logic [CTR_WIDTH-1:0]   InitVal = CTR_WIDTH'(INIT_VALUE);
  localparam logic [CTR_WIDTH-1:0]   CtrMax  = '1;

  typedef enum logic {StInit, StReady} state_e;

  state_e               r_state, w_state_nxt;
  logic [S_INDEX-1:0]   r_sweep_idx, w_sweep_nxt;
  logic [CTR_WIDTH-1:0] r_mem [Depth];

  logic                 w_init_wr;
  logic                 w_upd_acc;
  logic [CTR_WIDTH-1:0] w_upd_old;
  logic [CTR_WIDTH-1:0] w_upd_new;

  assign ready     = (r_state == StReady);
  assign w_upd_acc = upd_valid & ready & ~flush;
  assign w_upd_old = r_mem[upd_index];

  always_comb begin
    w_upd_new = w_upd_old;
    if (upd_taken && (w_upd_old != CtrMax)) begin
      w_upd_new = w_upd_old + CTR_WIDTH'(1);
    end else if (!upd_taken && (w_upd_old != '0)) begin
      w_upd_new = w_upd_old - CTR_WIDTH'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep_idx;
    w_init_wr   = 1'b0;
    if (flush) begin
      // Flush restarts the sweep without writing on this edge.
      w_state_nxt = StInit;
      w_sweep_nxt = '0;
    end else if (r_state == StInit) begin
      w_init_wr   = 1'b1;
      w_sweep_nxt = r_sweep_idx + S_INDEX'(1);
      if (r_sweep_idx == '1) begin
        w_state_nxt = StReady;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StInit;
      r_sweep_idx <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_idx <= w_sweep_nxt;
    end
  end

  // Storage is deliberately not reset; the sweep initialises it.
  always_ff @(posedge clk) begin
    if (w_init_wr) begin
      r_mem[r_sweep_idx] <= InitVal;
    end else if (w_upd_acc) begin
      r_mem[upd_index] <= w_upd_new;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [S_INDEX-1:0]   w_idx;
    logic [CTR_WIDTH-1:0] w_val;

    assign w_idx = rd_index[g*S_INDEX +: S_INDEX];

    always_comb begin
      w_val = r_mem[w_idx];
      if (r_state == StInit) begin
        w_val = InitVal;
      end else if (w_upd_acc && (w_idx == upd_index)) begin
        w_val = w_upd_new;
      end
    end

    assign rd_ctr[g*CTR_WIDTH +: CTR_WIDTH] = w_val;
    assign rd_taken[g]                      = w_val[CTR_WIDTH-1];
  end

endmodule
